id_ex_stage: RTL and testbench

- ID/EX pipeline register for the 5-stage WISC core, with load-use hazard detection.
- Registers decode outputs and produces the id_ex_srcReg1/2, id_ex_dstReg and id_ex_regWrite signals consumed by the forwarding unit.
- Detects load-use hazards that forwarding cannot cover. On a hazard it stalls PC and IF/ID and inserts a bubble.
- Squashes on branch flush, and freezes after HLT reaches EX.

---
 rtl/wisc_pkg.sv | 46 ++++
 rtl/load_use_detect.sv | 33 +++
 rtl/id_ex_stage.sv | 121 ++++++++++++
 tb/tb_id_ex_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// Shared WISC core types: widths, ALU opcodes and
// the ID/EX pipeline bundle.
package wisc_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 4;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'h0,
    ALU_SUB    = 4'h1,
    ALU_XOR    = 4'h2,
    ALU_RED    = 4'h3,
    ALU_SLL    = 4'h4,
    ALU_SRA    = 4'h5,
    ALU_ROR    = 4'h6,
    ALU_PADDSB = 4'h7,
    ALU_LW     = 4'h8,
    ALU_SW     = 4'h9,
    ALU_LLB    = 4'hA,
    ALU_LHB    = 4'hB,
    ALU_B      = 4'hC,
    ALU_BR     = 4'hD,
    ALU_PCS    = 4'hE,
    ALU_HLT    = 4'hF
  } aluOp_e;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  srcReg1;
    logic [REG_W-1:0]  srcReg2;
    logic [REG_W-1:0]  dstReg;
    logic              regWrite;
    logic              memRead;
    logic              memWrite;
    aluOp_e            aluOp;
    logic              halt;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] imm;
  } id_ex_t;

  localparam id_ex_t BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard equation between the instruction in
// ID and a load sitting in EX.
module load_use_detect #(
  parameter int REG_W = 4
) (
  input  logic             idValid,
  input  logic [REG_W-1:0] idSrcReg1,
  input  logic [REG_W-1:0] idSrcReg2,
  input  logic             idUsesSrc1,
  input  logic             idUsesSrc2,
  input  logic             idMemWrite,
  input  logic             exValid,
  input  logic             exMemRead,
  input  logic [REG_W-1:0] exDstReg,
  output logic             hazard
);

  logic src1Hit;
  logic src2Hit;
  logic loadInEx;

  assign loadInEx = idValid && exValid && exMemRead
                 && (exDstReg != '0);

  assign src1Hit = idUsesSrc1 && (idSrcReg1 == exDstReg);

  // store data comes through the mem-to-mem path
  assign src2Hit = idUsesSrc2 && (idSrcReg2 == exDstReg)
                && !idMemWrite;

  assign hazard = loadInEx && (src1Hit || src2Hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall,
// branch squash and halt freeze.
module id_ex_stage #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_srcReg1,
  input  logic [REG_W-1:0]  id_srcReg2,
  input  logic              id_uses_src1,
  input  logic              id_uses_src2,
  input  logic [REG_W-1:0]  id_dstReg,
  input  logic              id_regWrite,
  input  logic              id_memRead,
  input  logic              id_memWrite,
  input  logic [3:0]        id_aluOp,
  input  logic              id_halt,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              flush,
  output logic              stall,
  output logic              halted,
  output logic              id_ex_valid,
  output logic [REG_W-1:0]  id_ex_srcReg1,
  output logic [REG_W-1:0]  id_ex_srcReg2,
  output logic [REG_W-1:0]  id_ex_dstReg,
  output logic              id_ex_regWrite,
  output logic              id_ex_memRead,
  output logic              id_ex_memWrite,
  output logic [3:0]        id_ex_aluOp,
  output logic              id_ex_halt,
  output logic [DATA_W-1:0] id_ex_rdata1,
  output logic [DATA_W-1:0] id_ex_rdata2,
  output logic [DATA_W-1:0] id_ex_imm,
  output logic [CNT_W-1:0]  stall_count
);

  import wisc_pkg::*;

  typedef enum logic {RUN, HALTED} state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_e           state;
  state_e           stateNext;
  id_ex_t           exQ;
  id_ex_t           exD;
  logic             hazard;
  logic [CNT_W-1:0] stallCnt;

  load_use_detect #(
    .REG_W(REG_W)
  ) uLoadUse (
    .idValid   (id_valid),
    .idSrcReg1 (id_srcReg1),
    .idSrcReg2 (id_srcReg2),
    .idUsesSrc1(id_uses_src1),
    .idUsesSrc2(id_uses_src2),
    .idMemWrite(id_memWrite),
    .exValid   (exQ.valid),
    .exMemRead (exQ.memRead),
    .exDstReg  (exQ.dstReg),
    .hazard    (hazard)
  );

  assign stall  = hazard && !flush && (state == RUN);
  assign halted = (state == HALTED);

  always_comb begin
    stateNext = state;
    exD       = BUBBLE;
    if (state == RUN && exQ.valid && exQ.halt)
      stateNext = HALTED;
    if (state == RUN && !flush && !hazard) begin
      exD.valid    = id_valid;
      exD.srcReg1  = id_srcReg1;
      exD.srcReg2  = id_srcReg2;
      exD.dstReg   = id_dstReg;
      exD.regWrite = id_regWrite & id_valid;
      exD.memRead  = id_memRead & id_valid;
      exD.memWrite = id_memWrite & id_valid;
      exD.aluOp    = aluOp_e'(id_aluOp);
      exD.halt     = id_halt & id_valid;
      exD.rdata1   = id_rdata1;
      exD.rdata2   = id_rdata2;
      exD.imm      = id_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      exQ      <= BUBBLE;
      stallCnt <= '0;
    end else begin
      state <= stateNext;
      exQ   <= exD;
      if (stall && (stallCnt != '1))
        stallCnt <= stallCnt + CNT_ONE;
    end
  end

  assign stall_count    = stallCnt;
  assign id_ex_valid    = exQ.valid;
  assign id_ex_srcReg1  = exQ.srcReg1;
  assign id_ex_srcReg2  = exQ.srcReg2;
  assign id_ex_dstReg   = exQ.dstReg;
  assign id_ex_regWrite = exQ.regWrite;
  assign id_ex_memRead  = exQ.memRead;
  assign id_ex_memWrite = exQ.memWrite;
  assign id_ex_aluOp    = exQ.aluOp;
  assign id_ex_halt     = exQ.halt;
  assign id_ex_rdata1   = exQ.rdata1;
  assign id_ex_rdata2   = exQ.rdata2;
  assign id_ex_imm      = exQ.imm;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; a second narrow-counter
// instance shares the stimulus to reach saturation quickly.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [3:0]  id_srcReg1, id_srcReg2, id_dstReg, id_aluOp;
  logic        id_uses_src1, id_uses_src2;
  logic        id_regWrite, id_memRead, id_memWrite, id_halt;
  logic [15:0] id_rdata1, id_rdata2, id_imm;
  logic        flush;

  logic        stall, halted;
  logic        exValid, exRegWrite, exMemRead, exMemWrite, exHalt;
  logic [3:0]  exSrc1, exSrc2, exDst, exAluOp;
  logic [15:0] exRd1, exRd2, exImm, stallCount;

  logic        sStall, sHalted;
  logic        sValid, sRegWrite, sMemRead, sMemWrite, sHalt;
  logic [3:0]  sSrc1, sSrc2, sDst, sAluOp;
  logic [15:0] sRd1, sRd2, sImm;
  logic [3:0]  sCount;

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_srcReg1(id_srcReg1), .id_srcReg2(id_srcReg2),
    .id_uses_src1(id_uses_src1), .id_uses_src2(id_uses_src2),
    .id_dstReg(id_dstReg), .id_regWrite(id_regWrite),
    .id_memRead(id_memRead), .id_memWrite(id_memWrite),
    .id_aluOp(id_aluOp), .id_halt(id_halt),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
    .id_imm(id_imm), .flush(flush),
    .stall(stall), .halted(halted),
    .id_ex_valid(exValid), .id_ex_srcReg1(exSrc1),
    .id_ex_srcReg2(exSrc2), .id_ex_dstReg(exDst),
    .id_ex_regWrite(exRegWrite), .id_ex_memRead(exMemRead),
    .id_ex_memWrite(exMemWrite), .id_ex_aluOp(exAluOp),
    .id_ex_halt(exHalt), .id_ex_rdata1(exRd1),
    .id_ex_rdata2(exRd2), .id_ex_imm(exImm),
    .stall_count(stallCount)
  );

  id_ex_stage #(.CNT_W(4)) dutSat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_srcReg1(id_srcReg1), .id_srcReg2(id_srcReg2),
    .id_uses_src1(id_uses_src1), .id_uses_src2(id_uses_src2),
    .id_dstReg(id_dstReg), .id_regWrite(id_regWrite),
    .id_memRead(id_memRead), .id_memWrite(id_memWrite),
    .id_aluOp(id_aluOp), .id_halt(id_halt),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
    .id_imm(id_imm), .flush(flush),
    .stall(sStall), .halted(sHalted),
    .id_ex_valid(sValid), .id_ex_srcReg1(sSrc1),
    .id_ex_srcReg2(sSrc2), .id_ex_dstReg(sDst),
    .id_ex_regWrite(sRegWrite), .id_ex_memRead(sMemRead),
    .id_ex_memWrite(sMemWrite), .id_ex_aluOp(sAluOp),
    .id_ex_halt(sHalt), .id_ex_rdata1(sRd1),
    .id_ex_rdata2(sRd2), .id_ex_imm(sImm),
    .stall_count(sCount)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setIn(input logic v,
                       input logic [3:0] rs, input logic [3:0] rt,
                       input logic u1, input logic u2,
                       input logic [3:0] rd,
                       input logic rw, input logic mr,
                       input logic mw,
                       input logic [3:0] op, input logic h);
    id_valid     = v;
    id_srcReg1   = rs;
    id_srcReg2   = rt;
    id_uses_src1 = u1;
    id_uses_src2 = u2;
    id_dstReg    = rd;
    id_regWrite  = rw;
    id_memRead   = mr;
    id_memWrite  = mw;
    id_aluOp     = op;
    id_halt      = h;
    id_rdata1    = {4{rs}};
    id_rdata2    = {4{rt}};
    id_imm       = 16'h0010;
  endtask

  task automatic alu(input logic [3:0] rd, input logic [3:0] rs,
                     input logic [3:0] rt);
    setIn(1'b1, rs, rt, 1'b1, 1'b1, rd, 1'b1, 1'b0, 1'b0,
          4'h0, 1'b0);
  endtask

  task automatic lw(input logic [3:0] rd, input logic [3:0] base);
    setIn(1'b1, base, 4'h0, 1'b1, 1'b0, rd, 1'b1, 1'b1, 1'b0,
          4'h8, 1'b0);
  endtask

  task automatic sw(input logic [3:0] rt, input logic [3:0] base);
    setIn(1'b1, base, rt, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1,
          4'h9, 1'b0);
  endtask

  task automatic hlt();
    setIn(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0,
          4'hF, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    setIn(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0,
          4'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(exValid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_count", 32'(stallCount), 32'd0);
    rst_n = 1'b1;

    // reset asserted while a load-use stall is pending
    lw(4'd4, 4'd2);
    step();
    alu(4'd5, 4'd4, 4'd1);
    #1;
    chk("pre_rst_stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_stall", 32'(stall), 32'd0);
    chk("midrst_valid", 32'(exValid), 32'd0);
    chk("midrst_dst", 32'(exDst), 32'd0);
    chk("midrst_memrd", 32'(exMemRead), 32'd0);
    step();
    rst_n = 1'b1;

    // pass-through ADD R3,R1,R2
    alu(4'd3, 4'd1, 4'd2);
    step();
    chk("add_valid", 32'(exValid), 32'd1);
    chk("add_dst", 32'(exDst), 32'd3);
    chk("add_rw", 32'(exRegWrite), 32'd1);
    chk("add_src1", 32'(exSrc1), 32'd1);
    chk("add_rd1", 32'(exRd1), 32'h1111);
    chk("add_rd2", 32'(exRd2), 32'h2222);
    chk("add_imm", 32'(exImm), 32'h0010);
    chk("add_count", 32'(stallCount), 32'd0);

    // load-use: exactly one bubble
    lw(4'd4, 4'd2);
    step();
    chk("lw_memrd", 32'(exMemRead), 32'd1);
    chk("lw_op", 32'(exAluOp), 32'h8);
    alu(4'd5, 4'd4, 4'd1);
    #1;
    chk("lu_stall", 32'(stall), 32'd1);
    step();
    chk("lu_bubble", 32'(exValid), 32'd0);
    chk("lu_count", 32'(stallCount), 32'd1);
    chk("lu_stall_off", 32'(stall), 32'd0);
    step();
    chk("lu_cons_valid", 32'(exValid), 32'd1);
    chk("lu_cons_dst", 32'(exDst), 32'd5);

    // store data dependence only
    lw(4'd4, 4'd2);
    step();
    sw(4'd4, 4'd2);
    #1;
    chk("swdata_stall", 32'(stall), 32'd0);
    step();
    chk("swdata_mw", 32'(exMemWrite), 32'd1);
    chk("swdata_valid", 32'(exValid), 32'd1);

    // store base dependence
    lw(4'd4, 4'd2);
    step();
    sw(4'd6, 4'd4);
    #1;
    chk("swbase_stall", 32'(stall), 32'd1);
    step();
    chk("swbase_bubble", 32'(exValid), 32'd0);
    chk("swbase_count", 32'(stallCount), 32'd2);
    step();
    chk("swbase_mw", 32'(exMemWrite), 32'd1);

    // R0 destination load
    lw(4'd0, 4'd2);
    step();
    alu(4'd1, 4'd0, 4'd0);
    #1;
    chk("r0_stall", 32'(stall), 32'd0);
    step();
    chk("r0_dst", 32'(exDst), 32'd1);

    // flush beats hazard
    lw(4'd4, 4'd2);
    step();
    alu(4'd5, 4'd4, 4'd1);
    flush = 1'b1;
    #1;
    chk("flush_stall", 32'(stall), 32'd0);
    step();
    flush = 1'b0;
    chk("flush_bubble", 32'(exValid), 32'd0);
    chk("flush_count", 32'(stallCount), 32'd2);

    // invalid ID gives a bubble
    alu(4'd7, 4'd1, 4'd2);
    id_valid = 1'b0;
    step();
    chk("inv_valid", 32'(exValid), 32'd0);
    chk("inv_rw", 32'(exRegWrite), 32'd0);

    // 20 more stalls: main reaches 22, narrow counter pins at F
    for (int i = 0; i < 20; i++) begin
      lw(4'd4, 4'd2);
      step();
      alu(4'd5, 4'd4, 4'd1);
      step();
    end
    chk("cnt_main", 32'(stallCount), 32'd22);
    chk("cnt_sat", 32'(sCount), 32'hF);

    // halt, with a flush coincident with HLT in EX
    hlt();
    step();
    chk("hlt_ex", 32'(exHalt), 32'd1);
    chk("hlt_not_yet", 32'(halted), 32'd0);
    alu(4'd3, 4'd1, 4'd2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("halted", 32'(halted), 32'd1);
    step();
    chk("halt_freeze", 32'(exValid), 32'd0);
    step();
    chk("halt_freeze2", 32'(exValid), 32'd0);
    chk("halt_count", 32'(stallCount), 32'd22);

    rst_n = 1'b0;
    #1;
    chk("unhalt_rst", 32'(halted), 32'd0);
    chk("unhalt_cnt", 32'(stallCount), 32'd0);
    step();
    rst_n = 1'b1;
    alu(4'd3, 4'd1, 4'd2);
    step();
    chk("post_valid", 32'(exValid), 32'd1);
    chk("post_dst", 32'(exDst), 32'd3);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
